// File: rtl/sbox_share_arbiter.sv
// ============================================================================
// Module      : sbox_share_arbiter
// Description : Time-shares one combinational SBox between AES SubBytes and
//               key-expansion SubWord, one byte per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sbox_share_arbiter #(
    parameter int SB_BYTES = 16,
    parameter int KX_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sb_req,
    input  logic [8*SB_BYTES-1:0] sb_state_in,
    output logic                  sb_done,
    output logic [8*SB_BYTES-1:0] sb_state_out,
    input  logic                  kx_req,
    input  logic [8*KX_BYTES-1:0] kx_word_in,
    output logic                  kx_done,
    output logic [8*KX_BYTES-1:0] kx_word_out,
    output logic [7:0]            sbox_in,
    input  logic [7:0]            sbox_out,
    output logic                  busy
);

    localparam int IDX_W    = $clog2(SB_BYTES);
    localparam int KX_IDX_W = $clog2(KX_BYTES);

    localparam logic [IDX_W-1:0]    c_sb_last = IDX_W'(SB_BYTES - 1);
    localparam logic [KX_IDX_W-1:0] c_kx_last = KX_IDX_W'(KX_BYTES - 1);
    localparam logic [IDX_W-1:0]    c_idx_one = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN_SB = 2'd1,
        ST_RUN_KX = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_pend_sb;
    logic                    r_pend_kx;
    logic                    r_last_kx;
    logic [8*SB_BYTES-1:0]   r_sb_cap;
    logic [8*KX_BYTES-1:0]   r_kx_cap;
    logic [8*SB_BYTES-1:0]   r_sb_out;
    logic [8*KX_BYTES-1:0]   r_kx_out;
    logic                    r_sb_done;
    logic                    r_kx_done;

    logic                    w_eff_sb;
    logic                    w_eff_kx;
    logic                    w_grant_sb;
    logic                    w_grant_kx;
    logic                    w_last_byte;
    logic [KX_IDX_W-1:0]     w_kx_idx;

    assign w_eff_sb = r_pend_sb | sb_req;
    assign w_eff_kx = r_pend_kx | kx_req;
    assign w_kx_idx = r_idx[KX_IDX_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_grant_sb  = 1'b0;
        w_grant_kx  = 1'b0;
        w_last_byte = 1'b0;
        sbox_in     = 8'h00;
        case (r_state)
            ST_IDLE: begin
                // On a tie the requester that did not win last time goes first
                if (w_eff_sb && w_eff_kx) begin
                    w_grant_kx = ~r_last_kx;
                    w_grant_sb = r_last_kx;
                end else begin
                    w_grant_sb = w_eff_sb;
                    w_grant_kx = w_eff_kx;
                end
                if (w_grant_sb) begin
                    w_state_nxt = ST_RUN_SB;
                end else if (w_grant_kx) begin
                    w_state_nxt = ST_RUN_KX;
                end
            end
            ST_RUN_SB: begin
                sbox_in     = r_sb_cap[{r_idx, 3'b000} +: 8];
                w_last_byte = (r_idx == c_sb_last);
                if (w_last_byte) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN_KX: begin
                sbox_in     = r_kx_cap[{w_kx_idx, 3'b000} +: 8];
                w_last_byte = (w_kx_idx == c_kx_last);
                if (w_last_byte) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_pend_sb <= 1'b0;
            r_pend_kx <= 1'b0;
            r_last_kx <= 1'b0;
            r_sb_cap  <= '0;
            r_kx_cap  <= '0;
            r_sb_out  <= '0;
            r_kx_out  <= '0;
            r_sb_done <= 1'b0;
            r_kx_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            // A request arriving mid-operation stays latched for a later grant
            r_pend_sb <= w_eff_sb & ~w_grant_sb;
            r_pend_kx <= w_eff_kx & ~w_grant_kx;
            r_sb_done <= 1'b0;
            r_kx_done <= 1'b0;
            if (w_grant_sb) begin
                r_sb_cap  <= sb_state_in;
                r_idx     <= '0;
                r_last_kx <= 1'b0;
            end else if (w_grant_kx) begin
                r_kx_cap  <= kx_word_in;
                r_idx     <= '0;
                r_last_kx <= 1'b1;
            end else if (r_state == ST_RUN_SB) begin
                r_sb_out[{r_idx, 3'b000} +: 8] <= sbox_out;
                r_idx     <= r_idx + c_idx_one;
                r_sb_done <= w_last_byte;
            end else if (r_state == ST_RUN_KX) begin
                r_kx_out[{w_kx_idx, 3'b000} +: 8] <= sbox_out;
                r_idx     <= r_idx + c_idx_one;
                r_kx_done <= w_last_byte;
            end
        end
    end

    assign sb_done      = r_sb_done;
    assign kx_done      = r_kx_done;
    assign sb_state_out = r_sb_out;
    assign kx_word_out  = r_kx_out;
    assign busy         = (r_state != ST_IDLE);

endmodule

`default_nettype wire
